// File: rtl/fft_power_framer.sv
// Streams one complex FFT frame in, computes saturated |X|^2 for the low I bins and replays them as a gap-free burst.
// Optional macro LOG2_EN adds a floor-log2 compression stage ahead of the buffer.
module fft_power_framer #(
   parameter int IN_WIDTH  = 16,
   parameter int N_BINS    = 512,
   parameter int I         = 160,
   parameter int BIT_WIDTH = 32,
   parameter int LOG_FRAC  = 8
) (
   input  logic                        clk_in,
   input  logic                        rst_in,
   input  logic                        fft_in_valid,
   output logic                        fft_in_ready,
   input  logic signed [IN_WIDTH-1:0]  fft_in_re,
   input  logic signed [IN_WIDTH-1:0]  fft_in_im,
   input  logic                        fft_in_last,
   input  logic                        formant_busy,
   output logic                        power_valid,
   output logic [BIT_WIDTH-1:0]        power_data,
   output logic                        frame_dropped,
   output logic                        frame_error
);

   localparam int PROD_W = 2 * IN_WIDTH;
   localparam int SUM_W  = PROD_W + 1;
   localparam int CNT_W  = $clog2(N_BINS);
   localparam int ADDR_W = (I > 1) ? $clog2(I) : 1;
   localparam int EMIT_W = $clog2(I + 2);
   localparam int IDX_W  = $clog2(BIT_WIDTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CAPTURE,
      S_DRAIN,
      S_DROP,
      S_EMIT
   } state_t;

   state_t                     r_state;
   state_t                     w_state_next;
   logic                       r_ready;
   logic [CNT_W-1:0]           r_bin_cnt;
   logic [EMIT_W-1:0]          r_emit_cnt;
   logic                       r_frame_error;
   logic                       r_frame_dropped;
   logic                       r_rd_vld;
   logic [BIT_WIDTH-1:0]       r_rd_data;
   logic                       r_power_valid;
   logic [BIT_WIDTH-1:0]       r_power_data;

   logic                       r_s1_vld;
   logic [ADDR_W-1:0]          r_s1_addr;
   logic signed [PROD_W-1:0]   r_s1_re2;
   logic signed [PROD_W-1:0]   r_s1_im2;

   logic [BIT_WIDTH-1:0]       r_buf [0:I-1];

   logic                       w_accept;
   logic                       w_at_max;
   logic                       w_end;
   logic                       w_err;
   logic                       w_last_cap;
   logic                       w_emit_done;
   logic                       w_cap;
   logic                       w_drop_pulse;
   logic                       w_rd_en;
   logic [ADDR_W-1:0]          w_rd_addr;
   logic [SUM_W-1:0]           w_sum;
   logic [BIT_WIDTH-1:0]       w_sat;
   logic                       w_wr_en;
   logic [ADDR_W-1:0]          w_wr_addr;
   logic [BIT_WIDTH-1:0]       w_wr_data;

   // {msb index, LOG_FRAC bits below the msb (zero padded)}; zero maps to zero.
   function automatic logic [BIT_WIDTH-1:0] f_log2(input logic [BIT_WIDTH-1:0] v);
      logic [IDX_W-1:0]     msb;
      logic [BIT_WIDTH-1:0] sh;
      logic [BIT_WIDTH-1:0] res;
      msb = '0;
      for (int k = 0; k < BIT_WIDTH; k++) begin
         if (v[k]) msb = IDX_W'(k);
      end
      sh  = v << (IDX_W'(BIT_WIDTH - 1) - msb);
      res = '0;
      res[LOG_FRAC +: IDX_W]  = msb;
      res[LOG_FRAC-1:0]       = sh[BIT_WIDTH-2 -: LOG_FRAC];
      if (v == '0) res = '0;
      return res;
   endfunction

   assign w_accept     = fft_in_valid & r_ready;
   assign w_at_max     = (r_bin_cnt == CNT_W'(N_BINS - 1));
   assign w_end        = w_accept & (fft_in_last | w_at_max);
   assign w_err        = w_end & (fft_in_last ^ w_at_max);
   assign w_last_cap   = (r_bin_cnt == CNT_W'(I - 1));
   assign w_emit_done  = (r_emit_cnt == EMIT_W'(I + 1));
   assign w_cap        = w_accept & (((r_state == S_IDLE) & ~formant_busy) | (r_state == S_CAPTURE));
   assign w_drop_pulse = w_end & ((r_state == S_DROP) | ((r_state == S_IDLE) & formant_busy));
   assign w_rd_en      = (r_state == S_EMIT) && (r_emit_cnt < EMIT_W'(I));
   assign w_rd_addr    = ADDR_W'(r_emit_cnt);

   // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (w_end)             w_state_next = S_IDLE;
               else if (formant_busy) w_state_next = S_DROP;
               else if (w_last_cap)   w_state_next = S_DRAIN;
               else                   w_state_next = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            if (w_end)                       w_state_next = S_IDLE;
            else if (w_accept && w_last_cap) w_state_next = S_DRAIN;
         end
         S_DRAIN: begin
            if (w_end) w_state_next = w_err ? S_IDLE : S_EMIT;
         end
         S_DROP: begin
            if (w_end) w_state_next = S_IDLE;
         end
         S_EMIT: begin
            if (w_emit_done) w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_state         <= S_IDLE;
         r_ready         <= 1'b0;
         r_bin_cnt       <= '0;
         r_emit_cnt      <= '0;
         r_frame_error   <= 1'b0;
         r_frame_dropped <= 1'b0;
         r_rd_vld        <= 1'b0;
         r_power_valid   <= 1'b0;
         r_power_data    <= '0;
         r_s1_vld        <= 1'b0;
      end else begin
         r_state         <= w_state_next;
         r_ready         <= (w_state_next != S_EMIT);
         r_frame_error   <= w_err;
         r_frame_dropped <= w_drop_pulse;
         if (w_end)         r_bin_cnt <= '0;
         else if (w_accept) r_bin_cnt <= r_bin_cnt + 1'b1;
         if ((r_state == S_EMIT) && !w_emit_done) r_emit_cnt <= r_emit_cnt + 1'b1;
         else                                     r_emit_cnt <= '0;
         r_rd_vld        <= w_rd_en;
         r_power_valid   <= r_rd_vld;
         r_power_data    <= r_rd_vld ? r_rd_data : '0;
         r_s1_vld        <= w_cap;
      end
   end

   // Stage 1: squares of the real and imaginary parts.
   always_ff @(posedge clk_in) begin
      if (w_cap) begin
         r_s1_addr <= ADDR_W'(r_bin_cnt);
         r_s1_re2  <= fft_in_re * fft_in_re;
         r_s1_im2  <= fft_in_im * fft_in_im;
      end
   end

   // Stage 2: unsigned sum of two non-negative squares, saturated to the output width.
   assign w_sum = {1'b0, r_s1_re2} + {1'b0, r_s1_im2};

   generate
      if (BIT_WIDTH >= SUM_W) begin : g_nosat
         assign w_sat = BIT_WIDTH'(w_sum);
      end else begin : g_sat
         assign w_sat = (|w_sum[SUM_W-1:BIT_WIDTH]) ? '1 : w_sum[BIT_WIDTH-1:0];
      end
   endgenerate

`ifdef LOG2_EN
   logic                  r_s2_vld;
   logic [ADDR_W-1:0]     r_s2_addr;
   logic [BIT_WIDTH-1:0]  r_s2_val;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) r_s2_vld <= 1'b0;
      else         r_s2_vld <= r_s1_vld;
   end

   always_ff @(posedge clk_in) begin
      if (r_s1_vld) begin
         r_s2_addr <= r_s1_addr;
         r_s2_val  <= w_sat;
      end
   end

   assign w_wr_en   = r_s2_vld;
   assign w_wr_addr = r_s2_addr;
   assign w_wr_data = f_log2(r_s2_val);
`else
   assign w_wr_en   = r_s1_vld;
   assign w_wr_addr = r_s1_addr;
   assign w_wr_data = w_sat;
`endif

   // NOTE: the buffer has no reset; its contents are overwritten before every burst that reads them.
   always_ff @(posedge clk_in) begin
      if (w_wr_en) r_buf[w_wr_addr] <= w_wr_data;
      if (w_rd_en) r_rd_data <= r_buf[w_rd_addr];
   end

   assign fft_in_ready  = r_ready;
   assign power_valid   = r_power_valid;
   assign power_data    = r_power_data;
   assign frame_dropped = r_frame_dropped;
   assign frame_error   = r_frame_error;

endmodule

// File: doc/fft_power_framer.md
Name: fft_power_framer

Overview:
- Upstream neighbour of the formant estimator.
- Accepts one streamed complex FFT frame (N_BINS bins, valid/ready with a last marker) and computes |X|^2 for bins 0..I-1 in a 2-stage pipeline, storing the results in an internal buffer.
- Replays the buffered values as one gap-free burst of exactly I cycles, which is the contiguous fft_valid/fft_data stream the formant estimator requires.
- Drops whole frames while the estimator reports busy, and flags malformed frames.

Parameters:
- IN_WIDTH, 16, signed width of real and imaginary inputs.
- N_BINS, 512, bins per FFT frame; must satisfy I <= N_BINS-2.
- I, 160, number of low bins forwarded.
- BIT_WIDTH, 32, output power width; power values above 2^BIT_WIDTH-1 saturate to all-ones.
- LOG_FRAC, 8, fraction bits used only when LOG2_EN is defined.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  reset, asynchronous, active-low.
- fft_in_valid  in  1  input beat valid.
- fft_in_ready  out  1  input beat accepted when valid&ready on a clock edge.
- fft_in_re  in  IN_WIDTH  signed real part.
- fft_in_im  in  IN_WIDTH  signed imaginary part.
- fft_in_last  in  1  marks bin N_BINS-1.
- formant_busy  in  1  downstream estimator not idle.
- power_valid  out  1  burst valid; drives the estimator's fft_valid.
- power_data  out  BIT_WIDTH  power value; drives the estimator's fft_data.
- frame_dropped  out  1  one-cycle pulse: a frame was discarded because the estimator was busy.
- frame_error  out  1  one-cycle pulse: frame length mismatch.

Behaviour:
- Reset values while rst_in is low: fft_in_ready=0, power_valid=0, power_data=0, frame_dropped=0, frame_error=0, state=IDLE, bin counter=0.
  - All outputs are registered.
  - fft_in_ready rises on the first edge after reset deasserts.
- Reset asserted mid-operation aborts everything immediately. No partial burst resumes, and the buffer contents are don't-care.
- States:
  - IDLE: ready=1. The first accepted beat starts a frame.
    - If formant_busy=1 on that edge: go to DROP.
    - Else: treat the beat as bin 0 and go to CAPTURE.
    - formant_busy is sampled only at the frame start.
  - CAPTURE: ready=1. Each accepted beat increments bin_cnt.
    - Bins 0..I-1 enter the pipeline. Stage 1 registers re*re and im*im as signed products; stage 2 forms the unsigned sum, saturates it to BIT_WIDTH and writes buffer[bin].
    - After bin I-1 is accepted: go to DRAIN.
  - DRAIN: ready=1. Accept and discard beats until the frame ends, then go to EMIT.
  - DROP: ready=1. Discard beats until the frame ends; pulse frame_dropped on the edge that accepts the end beat; return to IDLE.
  - EMIT: ready=0.
    - power_valid=1 for exactly I consecutive cycles with power_data = buffer[0..I-1] in order.
    - The first valid cycle is the 2nd edge after the edge that accepted the end beat.
    - Afterwards power_valid=0, power_data=0, and the state returns to IDLE.
- Frame end is the beat with fft_in_last=1 or the beat with bin_cnt=N_BINS-1, whichever comes first.
- Length errors:
  - last arrives with bin_cnt < N_BINS-1: frame_error pulses on that edge.
  - bin_cnt reaches N_BINS-1 with last=0: frame_error pulses on that edge; the frame is considered ended.
  - A frame with an error is never emitted; the state returns to IDLE.
  - An error inside a DROP frame pulses both frame_error and frame_dropped.
- Input gaps (valid=0) anywhere in a frame are tolerated, and the output burst is still gap-free.
- Arithmetic widths:
  - Products are 2*IN_WIDTH bits and the sum is 2*IN_WIDTH+1 bits.
  - The maximum value is 2*(2^(IN_WIDTH-1))^2 = 2^31 at defaults, which fits in 32 bits without saturation.

Optional Feature:
- Macro: LOG2_EN.
- When defined, stage 2 is followed by a log stage (pipeline grows by 1; EMIT timing is unchanged because capture finishes before the frame ends).
  - Each stored value is floor-log2 compressed: {msb_index, next LOG_FRAC bits below the MSB}, zero-extended to BIT_WIDTH.
  - Bits below the MSB that do not exist are padded with 0.
  - An input of 0 maps to 0.
- When undefined: linear saturated power, with no extra logic.

Test Plan:
- Frame of 512 beats, bin k has re=k, im=0, formant_busy=0.
  - Expect power_valid high for exactly 160 consecutive cycles starting 2 edges after the last beat, with data 0,1,4,...,159^2=25281.
  - fft_in_ready=0 throughout the burst.
- Same frame with random valid gaps (about 50% duty) -> identical gap-free 160-cycle burst.
- Bin 0 re=-32768, im=-32768 -> first output 0x80000000, no saturation. Without LOG2_EN, re=3, im=4 -> 25.
- formant_busy=1 at bin 0, then 0 -> no power_valid; one frame_dropped pulse on the last beat. The next frame is emitted normally.
- last at bin 300 -> frame_error pulse at that edge, no burst. Frame of 512 beats with last never set -> frame_error at bin 511, no burst.
- Reset asserted on the 50th cycle of the burst -> power_valid=0 immediately; after release, ready=1 and a new frame is emitted in full. With LOG2_EN defined, power 25 (binary 11001) -> 0x00000490.
